// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/write-back stage and its multiplier.
package exec_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_AW     = 3;
    localparam int MUL_CYCLES = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_LI   = 4'd9,
        OP_MOV  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SEQ  = 4'd12,
        OP_CMOV = 4'd13,
        OP_MUL  = 4'd14
    } op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/exec_wb_stage_seq_mul8.sv
// Shift-add 8x8 multiplier: operands load on start_i, one partial-product bit per edge.
// done_o is high during the last iteration; product_o is then the final low 8 bits.
module seq_mul8
    import exec_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    logic              busy_q, busy_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_next;

    always_comb begin
        acc_next  = acc_q + (b_q[0] ? a_q : '0);
        done_o    = busy_q && (cnt_q == 3'(MUL_CYCLES - 1));
        product_o = acc_next;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;

        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = '0;
        end else if (busy_q) begin
            acc_d = acc_next;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 3'd1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage feeding the register file write port and the CB bit.
// Handshake: an instruction transfers on a rising edge where valid_i && ready_o.
module exec_wb_stage
    import exec_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        op_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              cb_i,
    output logic              write_o,
    output logic [REG_AW-1:0] write_addr_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              write_cb_o,
    output logic              cb_data_o
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wcb_q, wcb_d;
    logic              cbdat_q, cbdat_d;
    logic [REG_AW-1:0] mul_rd_q, mul_rd_d;

    op_e               op;
    logic              accept;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
    logic              cb_fwd;
    logic              mul_start, mul_done;
    logic [DATA_W-1:0] mul_product;

    assign op      = op_e'(op_i);
    assign ready_o = (state_q == ST_IDLE);
    assign accept  = valid_i && ready_o;

    // Bypass the result still sitting on the write port to a dependent instruction.
    always_comb begin
        rs_fwd = (write_q && waddr_q == rs_addr_i) ? wdata_q : rs_data_i;
        rt_fwd = (write_q && waddr_q == rt_addr_i) ? wdata_q : rt_data_i;
        cb_fwd = wcb_q ? cbdat_q : cb_i;
    end

    assign mul_start = accept && (op == OP_MUL);

    seq_mul8 u_mul (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (mul_start),
        .a_i       (rs_fwd),
        .b_i       (rt_fwd),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = 1'b0;
        wcb_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        cbdat_d  = cbdat_q;
        mul_rd_d = mul_rd_q;

        if (state_q == ST_MUL_RUN) begin
            if (mul_done) begin
                state_d = ST_IDLE;
                write_d = 1'b1;
                waddr_d = mul_rd_q;
                wdata_d = mul_product;
            end
        end else if (accept) begin
            waddr_d = rd_addr_i;
            unique case (op)
                OP_ADD:  begin write_d = 1'b1; wdata_d = rs_fwd + rt_fwd; end
                OP_SUB:  begin write_d = 1'b1; wdata_d = rs_fwd - rt_fwd; end
                OP_AND:  begin write_d = 1'b1; wdata_d = rs_fwd & rt_fwd; end
                OP_OR:   begin write_d = 1'b1; wdata_d = rs_fwd | rt_fwd; end
                OP_XOR:  begin write_d = 1'b1; wdata_d = rs_fwd ^ rt_fwd; end
                OP_NOT:  begin write_d = 1'b1; wdata_d = ~rs_fwd; end
                OP_SLL:  begin write_d = 1'b1; wdata_d = rs_fwd << rt_fwd[2:0]; end
                OP_SRL:  begin write_d = 1'b1; wdata_d = rs_fwd >> rt_fwd[2:0]; end
                OP_LI:   begin write_d = 1'b1; wdata_d = imm_i; end
                OP_MOV:  begin write_d = 1'b1; wdata_d = rs_fwd; end
                OP_SLT:  begin wcb_d = 1'b1; cbdat_d = ($signed(rs_fwd) < $signed(rt_fwd)); end
                OP_SEQ:  begin wcb_d = 1'b1; cbdat_d = (rs_fwd == rt_fwd); end
                OP_CMOV: begin
                    if (cb_fwd) begin
                        write_d = 1'b1;
                        wdata_d = rs_fwd;
                    end
                end
                OP_MUL:  begin
                    state_d  = ST_MUL_RUN;
                    mul_rd_d = rd_addr_i;
                    waddr_d  = waddr_q;
                end
                default: waddr_d = waddr_q;
            endcase
            // Ops that issue no write leave the address output untouched.
            if (!write_d) begin
                waddr_d = waddr_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wcb_q    <= 1'b0;
            cbdat_q  <= 1'b0;
            mul_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wcb_q    <= wcb_d;
            cbdat_q  <= cbdat_d;
            mul_rd_q <= mul_rd_d;
        end
    end

    assign write_o      = write_q;
    assign write_addr_o = waddr_q;
    assign write_data_o = wdata_q;
    assign write_cb_o   = wcb_q;
    assign cb_data_o    = cbdat_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed bench for exec_wb_stage with hand-computed expected values.
module tb_exec_wb_stage;
    import exec_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] op_i;
    logic [2:0] rd_addr_i, rs_addr_i, rt_addr_i;
    logic [7:0] rs_data_i, rt_data_i, imm_i;
    logic       cb_i;
    logic       write_o;
    logic [2:0] write_addr_o;
    logic [7:0] write_data_o;
    logic       write_cb_o;
    logic       cb_data_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    exec_wb_stage dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .rd_addr_i    (rd_addr_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .imm_i        (imm_i),
        .cb_i         (cb_i),
        .write_o      (write_o),
        .write_addr_o (write_addr_o),
        .write_data_o (write_data_o),
        .write_cb_o   (write_cb_o),
        .cb_data_o    (cb_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rsa,
                         input logic [2:0] rta, input logic [7:0] rsd, input logic [7:0] rtd,
                         input logic [7:0] imm, input logic cb);
        valid_i   = 1'b1;
        op_i      = op;
        rd_addr_i = rd;
        rs_addr_i = rsa;
        rt_addr_i = rta;
        rs_data_i = rsd;
        rt_data_i = rtd;
        imm_i     = imm;
        cb_i      = cb;
    endtask

    // Present one instruction for a single edge, then sample just after that edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rsa,
                         input logic [2:0] rta, input logic [7:0] rsd, input logic [7:0] rtd,
                         input logic [7:0] imm, input logic cb);
        @(negedge clk_i);
        drive(op, rd, rsa, rta, rsd, rtd, imm, cb);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    int   busy;
    logic saw_write;

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        op_i = '0; rd_addr_i = '0; rs_addr_i = '0; rt_addr_i = '0;
        rs_data_i = '0; rt_data_i = '0; imm_i = '0; cb_i = 1'b0;

        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_write",  write_o, 0);
        check_eq("rst_wcb",    write_cb_o, 0);
        check_eq("rst_addr",   write_addr_o, 0);
        check_eq("rst_data",   write_data_o, 0);
        check_eq("rst_cbdata", cb_data_o, 0);
        check_eq("rst_ready",  ready_o, 1);
        @(negedge clk_i);
        reset_i = 1'b0;

        // LI r1,0x7F then dependent ADD r2,r1,r1 with stale register data
        issue(OP_LI, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h7F, 1'b0);
        check_eq("li_write", write_o, 1);
        check_eq("li_addr",  write_addr_o, 1);
        check_eq("li_data",  write_data_o, 8'h7F);
        issue(OP_ADD, 3'd2, 3'd1, 3'd1, 8'h00, 8'h00, 8'h00, 1'b0);
        check_eq("add_fwd_write", write_o, 1);
        check_eq("add_fwd_addr",  write_addr_o, 2);
        check_eq("add_fwd_data",  write_data_o, 8'hFE);
        idle_cycle();
        check_eq("idle_write", write_o, 0);
        check_eq("idle_hold",  write_data_o, 8'hFE);

        issue(OP_SUB, 3'd3, 3'd4, 3'd5, 8'h05, 8'h07, 8'h00, 1'b0);
        check_eq("sub_addr", write_addr_o, 3);
        check_eq("sub_data", write_data_o, 8'hFE);
        issue(OP_SLL, 3'd4, 3'd5, 3'd6, 8'h81, 8'h09, 8'h00, 1'b0);
        check_eq("sll_data", write_data_o, 8'h02);

        // SLT -128 < 1, then CMOV must see the forwarded CB, not cb_i
        issue(OP_SLT, 3'd0, 3'd5, 3'd6, 8'h80, 8'h01, 8'h00, 1'b0);
        check_eq("slt_wcb",   write_cb_o, 1);
        check_eq("slt_cb",    cb_data_o, 1);
        check_eq("slt_write", write_o, 0);
        issue(OP_CMOV, 3'd5, 3'd6, 3'd6, 8'h5A, 8'h00, 8'h00, 1'b0);
        check_eq("cmov_write", write_o, 1);
        check_eq("cmov_wcb",   write_cb_o, 0);
        check_eq("cmov_addr",  write_addr_o, 5);
        check_eq("cmov_data",  write_data_o, 8'h5A);
        issue(OP_CMOV, 3'd6, 3'd6, 3'd6, 8'h33, 8'h00, 8'h00, 1'b0);
        check_eq("cmov_nocb_write", write_o, 0);
        check_eq("cmov_nocb_hold",  write_data_o, 8'h5A);

        // MUL 0x0F*0x11 with an ADD held on the inputs during the busy window
        issue(OP_MUL, 3'd6, 3'd1, 3'd2, 8'h0F, 8'h11, 8'h00, 1'b0);
        busy = 0;
        saw_write = 1'b0;
        if (!ready_o) busy = 1;
        @(negedge clk_i);
        drive(OP_ADD, 3'd7, 3'd1, 3'd2, 8'h01, 8'h02, 8'h00, 1'b0);
        while (!ready_o && busy < 20) begin
            @(posedge clk_i);
            #1;
            if (!ready_o) begin
                busy++;
                if (write_o) saw_write = 1'b1;
            end
        end
        check_eq("mul_busy_cycles", busy, 8);
        check_eq("mul_no_early_wr", saw_write, 0);
        check_eq("mul_write", write_o, 1);
        check_eq("mul_addr",  write_addr_o, 6);
        check_eq("mul_data",  write_data_o, 8'hFF);
        @(posedge clk_i);
        #1;
        check_eq("held_add_write", write_o, 1);
        check_eq("held_add_addr",  write_addr_o, 7);
        check_eq("held_add_data",  write_data_o, 8'h03);
        idle_cycle();

        issue(OP_SEQ, 3'd0, 3'd1, 3'd2, 8'h3C, 8'h3C, 8'h00, 1'b0);
        check_eq("seq_wcb", write_cb_o, 1);
        check_eq("seq_cb",  cb_data_o, 1);
        issue(OP_CMOV, 3'd0, 3'd3, 3'd3, 8'h11, 8'h00, 8'h00, 1'b0);
        check_eq("seq_cmov_write", write_o, 1);
        check_eq("seq_cmov_data",  write_data_o, 8'h11);
        issue(4'hF, 3'd2, 3'd3, 3'd3, 8'h44, 8'h44, 8'h44, 1'b1);
        check_eq("undef_write", write_o, 0);
        check_eq("undef_wcb",   write_cb_o, 0);
        check_eq("undef_hold",  write_data_o, 8'h11);
        check_eq("undef_ready", ready_o, 1);

        // Reset during the 4th MUL cycle aborts it without any write
        issue(OP_MUL, 3'd7, 3'd4, 3'd5, 8'h03, 8'h05, 8'h00, 1'b0);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check_eq("mrst_write",  write_o, 0);
        check_eq("mrst_data",   write_data_o, 0);
        check_eq("mrst_addr",   write_addr_o, 0);
        check_eq("mrst_cbdata", cb_data_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check_eq("mrst_ready", ready_o, 1);
        saw_write = 1'b0;
        repeat (12) begin
            @(posedge clk_i);
            #1;
            if (write_o) saw_write = 1'b1;
        end
        check_eq("mrst_no_write", saw_write, 0);
        check_eq("mrst_data_end", write_data_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Execute/write-back stage directly upstream of the 8x8-bit register file and its conditional bit (CB).
- Consumes decoded instructions plus rs/rt operands read from the register file, computes 8-bit results or CB updates, and drives the register-file write port from registered outputs.
- Forwards its own pending result to back-to-back dependent instructions.
- Holds a multi-cycle 8x8 multiplier; the upstream decoder is back-pressured with ready_o while it runs.

Parameters:
- MUL_CYCLES, 8, edges the multiplier iterates before its result is registered (one partial-product bit per edge); fixed 8 for 8-bit operands.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  instruction present.
- ready_o  out  1  stage can accept; transfer occurs on an edge with valid_i && ready_o.
- op_i  in  4  opcode (package enum).
- rd_addr_i  in  3  destination register.
- rs_addr_i  in  3  rs source address (for forwarding compare).
- rt_addr_i  in  3  rt source address (for forwarding compare).
- rs_data_i  in  8  rs operand from register file.
- rt_data_i  in  8  rt operand from register file.
- imm_i  in  8  immediate.
- cb_i  in  1  current CB from register file.
- write_o  out  1  register write strobe.
- write_addr_o  out  3  register write address.
- write_data_o  out  8  register write data.
- write_cb_o  out  1  CB write strobe.
- cb_data_o  out  1  CB write value.

Behaviour:
- Reset (async, any state): write_o=0, write_cb_o=0, write_addr_o=0, write_data_o=0, cb_data_o=0, FSM=IDLE, multiplier counter=0. ready_o=1 once IDLE. Reset mid-MUL aborts it; no write is ever issued for the aborted op.
- FSM states:
  - IDLE: ready_o=1. On accept of MUL -> MUL_RUN. On accept of any other op -> stays IDLE.
  - MUL_RUN: ready_o=0, counter 0..MUL_CYCLES-1. On the edge where counter==MUL_CYCLES-1, the result is registered and the FSM returns to IDLE.
- Output strobes: write_o and write_cb_o are one-cycle pulses. Each edge with no write event clears both to 0. Address/data outputs hold their last value.
- Latency:
  - Single-cycle ops: result on outputs immediately after the accepting edge.
  - MUL: result on outputs after the 8th edge following accept; ready_o is low for exactly 8 cycles.
- Forwarding (evaluated at accept, combinational on inputs):
  - rs operand = write_data_o if write_o && write_addr_o==rs_addr_i, else rs_data_i. Same rule for rt.
  - CB = cb_data_o if write_cb_o, else cb_i.
  - MUL operands are captured with forwarding at accept.
- Ops (all arithmetic mod 256):
  - ADD: rd=rs+rt. SUB: rd=rs-rt. AND, OR, XOR: bitwise. NOT: rd=~rs.
  - SLL/SRL: shift rs by rt[2:0], zero fill.
  - LI: rd=imm_i. MOV: rd=rs.
  - SLT: CB=(signed rs < signed rt), two's complement.
  - SEQ: CB=(rs==rt).
  - CMOV: rd=rs only if forwarded CB==1; otherwise no write.
  - MUL: rd=low 8 bits of rs*rt, unsigned.
  - Undefined opcode: accepted as NOP, no strobes.
- CB ops assert write_cb_o only; register ops assert write_o only; never both.
- valid_i while ready_o=0: ignored. Upstream must hold the instruction stable until accepted.

Decomposition:
- Shared package exec_pkg:
  - opcode enum: NOP, ADD, SUB, AND, OR, XOR, NOT, SLL, SRL, LI, MOV, SLT, SEQ, CMOV, MUL.
  - constants DATA_W=8, REG_AW=3.
  - FSM state type.
- Sub-module seq_mul8: start/done handshake, shift-add, 8 iterations, 8-bit product output. Instantiated once; the stage owns the FSM.

Test Plan:
- Reset asserted during the 4th MUL cycle -> outputs 0 immediately, ready_o=1 after release, no write_o pulse ever appears for that MUL.
- LI r1,0x7F then ADD r2,r1,r1 back-to-back (rs_data_i stale 0x00) -> write_o pulses r1=0x7F, then r2=0xFE via forwarding.
- SUB r3=0x05-0x07 -> write_data_o=0xFE. SLL 0x81 by rt=0x09 (amount 1) -> 0x02.
- SLT rs=0x80 (-128), rt=0x01 -> write_cb_o=1, cb_data_o=1. Next CMOV with cb_i=0 -> write_o=1, using the forwarded CB.
- MUL 0x0F*0x11 -> ready_o low 8 cycles, then write_data_o=0xFF. Hold valid_i with ADD during the busy window -> ADD accepted only after ready_o rises, result one edge later.
- SEQ rs=rt=0x3C -> CB=1. CMOV then writes. Undefined opcode -> no strobes for that cycle.
